dmem_arbiter: RTL and testbench

//   Arbitrates one shared single-port data memory between two requesters.

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shared single-port data memory arbiter between the CPU MEM stage (port C)
// and the debug/loader port (port D). Each access occupies the memory for
// MEM_LAT cycles, followed by a one-cycle ack. C has fixed priority, except
// when D has lost STARVE_MAX decisions in a row.
module dmem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // CPU port
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [31:0]       c_wdata_i,
  output logic [31:0]       c_rdata_o,
  output logic              c_ack_o,
  output logic              c_stall_o,
  // Debug port
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic [31:0]       d_rdata_o,
  output logic              d_ack_o,
  // Memory port
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [31:0]       m_wdata_o,
  input  logic [31:0]       m_rdata_i,
  // Statistics
  output logic [31:0]       stall_cnt_o
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned StvW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q;
  logic [LatW-1:0]   lat_cnt_q;
  logic [StvW-1:0]   starve_cnt_q;
  logic              win_d_q;
  logic [31:0]       stall_cnt_q;
  logic              starved;
  logic              d_wins;

  // D wins when C is absent, or when D has been passed over too often.
  assign starved     = (starve_cnt_q == StvW'(STARVE_MAX));
  assign d_wins      = d_req_i & (~c_req_i | starved);
  assign c_stall_o   = c_req_i & ~c_ack_o;
  assign stall_cnt_o = stall_cnt_q;

  // Access sequencer: grant in IDLE, count latency in BUSY, pulse ack in RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      lat_cnt_q <= '0;
      win_d_q   <= 1'b0;
      m_req_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      c_ack_o   <= 1'b0;
      d_ack_o   <= 1'b0;
      c_rdata_o <= '0;
      d_rdata_o <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (c_req_i | d_req_i) begin
            win_d_q   <= d_wins;
            m_we_o    <= d_wins ? d_we_i    : c_we_i;
            m_addr_o  <= d_wins ? d_addr_i  : c_addr_i;
            m_wdata_o <= d_wins ? d_wdata_i : c_wdata_i;
            m_req_o   <= 1'b1;
            lat_cnt_q <= LatW'(MEM_LAT - 1);
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          if (lat_cnt_q != '0) begin
            lat_cnt_q <= lat_cnt_q - LatW'(1);
          end else begin
            m_req_o <= 1'b0;
            state_q <= StResp;
            if (win_d_q) begin
              d_ack_o <= 1'b1;
              if (!m_we_o) d_rdata_o <= m_rdata_i;
            end else begin
              c_ack_o <= 1'b1;
              if (!m_we_o) c_rdata_o <= m_rdata_i;
            end
          end
        end
        StResp: begin
          c_ack_o <= 1'b0;
          d_ack_o <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Starvation counter: counts IDLE decisions D lost; cleared on D grant or D idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else if (!d_req_i) begin
      starve_cnt_q <= '0;
    end else if (state_q == StIdle) begin
      if (d_wins) begin
        starve_cnt_q <= '0;
      end else begin
        starve_cnt_q <= starve_cnt_q + StvW'(1);
      end
    end
  end

  // Saturating count of CPU stall cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (c_stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level timing model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

  localparam int MemLat    = 2;
  localparam int StarveMax = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        c_req_i = 1'b0, c_we_i = 1'b0;
  logic [31:0] c_addr_i = '0, c_wdata_i = '0;
  logic [31:0] c_rdata_o;
  logic        c_ack_o, c_stall_o;
  logic        d_req_i = 1'b0, d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0, d_wdata_i = '0;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        m_req_o, m_we_o;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic [31:0] stall_cnt_o;

  dmem_arbiter #(
    .MEM_LAT   (MemLat),
    .STARVE_MAX(StarveMax),
    .ADDR_W    (32)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .c_req_i    (c_req_i),
    .c_we_i     (c_we_i),
    .c_addr_i   (c_addr_i),
    .c_wdata_i  (c_wdata_i),
    .c_rdata_o  (c_rdata_o),
    .c_ack_o    (c_ack_o),
    .c_stall_o  (c_stall_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_rdata_o  (d_rdata_o),
    .d_ack_o    (d_ack_o),
    .m_req_o    (m_req_o),
    .m_we_o     (m_we_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_rdata_i  (m_rdata_i),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int tcyc   = 0;
  logic chk_en = 1'b1;

  always @(posedge clk_i) tcyc <= tcyc + 1;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'd5 : (32'hA000_0000 | 32'(i));
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  // Memory responder: combinational read of the presented address, writes while active.
  logic [31:0] resp_mem [16];
  assign m_rdata_i = resp_mem[m_addr_o[5:2]];
  initial begin
    for (int i = 0; i < 16; i++) resp_mem[i] = init_word(i);
    forever begin
      @(posedge clk_i);
      if (m_req_o && m_we_o) resp_mem[m_addr_o[5:2]] <= m_wdata_o;
    end
  end

  // ---------------- Transaction-level reference model ----------------
  logic [31:0] mdl_mem [16];
  int          cyc, free_at, g_edge, starve;
  logic        busy, g_d, g_we;
  logic [31:0] g_addr, g_wdata, g_rdata;
  logic        e_mreq, e_mwe, e_cack, e_dack;
  logic [31:0] e_maddr, e_mwdata, e_crdata, e_drdata, e_stall;

  task automatic model_reset();
    cyc = 0; free_at = 0; g_edge = 0; starve = 0; busy = 1'b0;
    e_mreq = 1'b0; e_mwe = 1'b0; e_maddr = '0; e_mwdata = '0;
    e_cack = 1'b0; e_dack = 1'b0; e_crdata = '0; e_drdata = '0; e_stall = '0;
  endtask

  // One clock edge: an access granted at edge G owns the memory after edges
  // G..G+MemLat-1, acks after edge G+MemLat, and the next grant is at G+MemLat+2.
  task automatic model_step();
    logic dw;
    int   idx;
    if (c_req_i && !e_cack && (e_stall != 32'hFFFF_FFFF)) e_stall = e_stall + 32'd1;
    e_cack = 1'b0;
    e_dack = 1'b0;
    if (busy && (cyc == g_edge + MemLat)) begin
      busy = 1'b0;
      if (g_d) begin
        e_dack = 1'b1;
        if (!g_we) e_drdata = g_rdata;
      end else begin
        e_cack = 1'b1;
        if (!g_we) e_crdata = g_rdata;
      end
    end
    if (!busy && (cyc >= free_at) && (c_req_i || d_req_i)) begin
      dw      = d_req_i && (!c_req_i || (starve == StarveMax));
      g_d     = dw;
      g_we    = dw ? d_we_i : c_we_i;
      g_addr  = dw ? d_addr_i : c_addr_i;
      g_wdata = dw ? d_wdata_i : c_wdata_i;
      idx     = int'(g_addr[5:2]);
      g_rdata = mdl_mem[idx];
      if (g_we) mdl_mem[idx] = g_wdata;
      busy    = 1'b1;
      g_edge  = cyc;
      free_at = cyc + MemLat + 2;
      if (dw) starve = 0;
      else if (d_req_i) starve = starve + 1;
      e_mwe    = g_we;
      e_maddr  = g_addr;
      e_mwdata = g_wdata;
    end
    if (!d_req_i) starve = 0;
    e_mreq = busy && ((cyc - g_edge) < MemLat);
    cyc = cyc + 1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl_mem[i] = init_word(i);
    model_reset();
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && chk_en) begin
        check1 ("m_req",   m_req_o,     e_mreq);
        check1 ("m_we",    m_we_o,      e_mwe);
        check32("m_addr",  m_addr_o,    e_maddr);
        check32("m_wdata", m_wdata_o,   e_mwdata);
        check1 ("c_ack",   c_ack_o,     e_cack);
        check1 ("d_ack",   d_ack_o,     e_dack);
        check32("c_rdata", c_rdata_o,   e_crdata);
        check32("d_rdata", d_rdata_o,   e_drdata);
        check32("stall",   stall_cnt_o, e_stall);
        check1 ("c_stall", c_stall_o,   c_req_i & ~e_cack);
      end
    end
  end

  // ---------------- Directed stimulus ----------------
  string grant_log;
  int    c_ack_t[$];
  int    d_ack_t[$];

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  // Hold requests until n_c C acks and n_d D acks are seen (renewing in between).
  task automatic serve(input int n_c, input int n_d, input int max_cyc);
    int nc = 0;
    int nd = 0;
    grant_log = "";
    c_ack_t.delete();
    d_ack_t.delete();
    for (int k = 0; (k < max_cyc) && ((nc < n_c) || (nd < n_d)); k++) begin
      tick();
      if (c_ack_o) begin
        nc++;
        c_ack_t.push_back(tcyc);
        grant_log = {grant_log, "C"};
        if (nc >= n_c) c_req_i = 1'b0;
      end
      if (d_ack_o) begin
        nd++;
        d_ack_t.push_back(tcyc);
        grant_log = {grant_log, "D"};
        if (nd >= n_d) d_req_i = 1'b0;
      end
    end
    if ((nc < n_c) || (nd < n_d)) begin
      check_int("serve_timeout_acks", nc + nd, n_c + n_d);
      c_req_i = 1'b0;
      d_req_i = 1'b0;
    end
  endtask

  task automatic c_set(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    c_req_i = 1'b1; c_we_i = we; c_addr_i = addr; c_wdata_i = wdata;
  endtask

  task automatic d_set(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    tick(); tick();
    rst_i = 1'b0;
    tick();
    check1 ("rst_m_req",  m_req_o,     1'b0);
    check1 ("rst_c_ack",  c_ack_o,     1'b0);
    check32("rst_stall",  stall_cnt_o, 32'd0);
    check32("rst_c_rdata", c_rdata_o,  32'd0);

    // 1: C read of address 0 returns 5 after three stall cycles.
    t0 = tcyc;
    c_set(1'b0, 32'h00, 32'h0);
    serve(1, 0, 20);
    check_int("t1_latency", (c_ack_t.size() > 0) ? c_ack_t[0] - t0 : -1, 3);
    check32("t1_rdata", c_rdata_o, 32'd5);
    check32("t1_stall", stall_cnt_o, 32'd3);
    tick();

    // 2: C write 0x1234 to address 4; payload held for both busy cycles.
    c_set(1'b1, 32'h04, 32'h1234);
    for (int k = 0; k < 2; k++) begin
      tick();
      check1 ("t2_m_req",   m_req_o,   1'b1);
      check1 ("t2_m_we",    m_we_o,    1'b1);
      check32("t2_m_addr",  m_addr_o,  32'h04);
      check32("t2_m_wdata", m_wdata_o, 32'h1234);
    end
    tick();
    check1 ("t2_ack",   c_ack_o,   1'b1);
    check32("t2_rdata", c_rdata_o, 32'd5);
    c_req_i = 1'b0;
    tick();

    // 3: simultaneous C and D; C first, D acks four cycles later.
    c_set(1'b0, 32'h04, 32'h0);
    d_set(1'b0, 32'h08, 32'h0);
    serve(1, 1, 30);
    check_str("t3_order", grant_log, "CD");
    check_int("t3_gap", (c_ack_t.size() > 0 && d_ack_t.size() > 0) ?
              d_ack_t[0] - c_ack_t[0] : -1, 4);
    check32("t3_c_rdata", c_rdata_o, 32'h1234);
    check32("t3_d_rdata", d_rdata_o, 32'hA000_0002);
    tick();

    // 4: C back-to-back with D held; D forced through every third grant.
    c_set(1'b0, 32'h0C, 32'h0);
    d_set(1'b0, 32'h10, 32'h0);
    serve(4, 2, 80);
    check_str("t4_order", grant_log, "CCDCCD");
    check32("t4_d_rdata", d_rdata_o, 32'hA000_0004);
    tick();

    // 5: asynchronous reset in the middle of an access.
    c_set(1'b0, 32'h14, 32'h0);
    tick();
    check1("t5_busy", m_req_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check1("t5_m_req_async", m_req_o, 1'b0);
    check1("t5_ack_async",   c_ack_o, 1'b0);
    c_req_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check1("t5_no_ack", c_ack_o, 1'b0);
      check1("t5_idle",   m_req_o, 1'b0);
    end
    t0 = tcyc;
    c_set(1'b0, 32'h14, 32'h0);
    serve(1, 0, 20);
    check_int("t5_latency", (c_ack_t.size() > 0) ? c_ack_t[0] - t0 : -1, 3);
    check32("t5_rdata", c_rdata_o, 32'hA000_0005);
    check32("t5_stall", stall_cnt_o, 32'd3);
    tick();

    // 6: stall counter saturates at all-ones.
    chk_en = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.stall_cnt_q;
    e_stall = 32'hFFFF_FFFE;
    chk_en  = 1'b1;
    tick();
    check32("t6_preload", stall_cnt_o, 32'hFFFF_FFFE);
    c_set(1'b0, 32'h18, 32'h0);
    tick();
    check32("t6_first", stall_cnt_o, 32'hFFFF_FFFF);
    serve(1, 0, 20);
    check32("t6_sat", stall_cnt_o, 32'hFFFF_FFFF);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
